// File: rtl/gpool_pkg.sv
// Purpose: shared fixed-point format, FSM states and saturation helper for global pooling.
// Latency: n/a (types and a combinational function only).
// Backpressure: n/a.
package gpool_pkg;

  localparam int IL       = 4;
  localparam int FL       = 16;
  localparam int MAX_SIZE = 1024;
  localparam int DW       = IL + FL;
  localparam int CW       = $clog2(MAX_SIZE + 1);
  localparam int ACC_W    = DW + CW;
  localparam int PROD_W   = ACC_W + DW;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  typedef logic signed [DW-1:0]     fx_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  // Floor-shift an acc*recip product back to IL.FL and clamp to the fx_t range.
  function automatic fx_t sat_fx(input prod_t acc_product);
    prod_t sh;
    sh = acc_product >>> DW;
    if (sh[PROD_W-1:DW-1] == '0 || sh[PROD_W-1:DW-1] == '1)
      sat_fx = sh[DW-1:0];
    else if (sh[PROD_W-1])
      sat_fx = {1'b1, {(DW-1){1'b0}}};
    else
      sat_fx = {1'b0, {(DW-1){1'b1}}};
  endfunction

endpackage

// File: rtl/gpool_lane.sv
// Purpose: per-channel accumulator (avg) or running maximum (max) register.
// Latency: value updates on the clock after a beat; val_d exposes the next value combinationally.
// Backpressure: none; beats are qualified by ld from the parent.
module gpool_lane
  import gpool_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic ld,
  input  logic first,
  input  logic mode,
  input  fx_t  din,
  output acc_t val_d
);

  acc_t val;

  // Next value: clear at job start, otherwise sum or keep the strictly-greater element.
  always_comb begin
    val_d = val;
    if (clr) begin
      val_d = '0;
    end else if (ld) begin
      if (!mode)
        val_d = val + acc_t'(din);
      else if (first || din > fx_t'(val[DW-1:0]))
        val_d = acc_t'(din);
    end
  end

  // Lane state register.
  always_ff @(posedge clk) begin
    if (rst) val <= '0;
    else     val <= val_d;
  end

endmodule

// File: rtl/global_pool_mc.sv
// Purpose: multi-channel global avg/max pooling over a channel-interleaved IL.FL stream.
// Latency: first result the cycle after the last input beat, then one channel per output handshake.
// Backpressure: in_ready only in ACCUM; results held stable while out_valid && !out_ready.
module global_pool_mc
  import gpool_pkg::*;
#(
  parameter  int NCH = 8,
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mode,
  input  logic [CW-1:0] size,
  input  logic [DW-1:0] recip,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [CHW-1:0] out_ch,
  output logic          busy,
  output logic          done
);

  state_t         state, nxt;
  logic           mode_q;
  logic [CW-1:0]  size_q, elem_q;
  logic [DW-1:0]  recip_q;
  logic [CHW-1:0] ch_q, sel_ch;
  logic           beat, last_ch, last_beat, out_hs, last_out, clr;
  acc_t           lane_val [NCH];
  acc_t           sel_acc;
  prod_t          prod;
  fx_t            result;

  assign in_ready  = (state == ACCUM);
  assign busy      = (state != IDLE);
  assign beat      = in_valid && in_ready;
  assign last_ch   = (ch_q == CHW'(NCH - 1));
  assign last_beat = beat && last_ch && (elem_q == size_q - 1'b1);
  assign out_hs    = out_valid && out_ready;
  assign last_out  = out_hs && (out_ch == CHW'(NCH - 1));
  assign clr       = (state == IDLE) && start;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    gpool_lane u_lane (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .ld    (beat && (ch_q == CHW'(c))),
      .first (elem_q == '0),
      .mode  (mode_q),
      .din   (fx_t'(in_data)),
      .val_d (lane_val[c])
    );
  end

  // Next-state logic; a zero-size job skips straight to DONE.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = (size == '0) ? DONE : ACCUM;
      ACCUM:   if (last_beat) nxt = DRAIN;
      DRAIN:   if (last_out) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Select the channel about to be registered into the output and scale/saturate it.
  // Lanes' next values are used so the channel receiving the final beat is already complete.
  always_comb begin
    sel_ch  = (state == ACCUM) ? '0 : out_ch + 1'b1;
    sel_acc = '0;
    for (int c = 0; c < NCH; c++)
      if (sel_ch == CHW'(c)) sel_acc = lane_val[c];
    prod   = prod_t'(sel_acc) * prod_t'($signed({1'b0, recip_q}));
    result = mode_q ? fx_t'(sel_acc[DW-1:0]) : sat_fx(prod);
  end

  // Control registers: job parameters, beat/channel counters, output register, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      size_q    <= '0;
      recip_q   <= '0;
      ch_q      <= '0;
      elem_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      done      <= 1'b0;
    end else begin
      state <= nxt;
      done  <= (nxt == DONE);
      if (clr) begin
        mode_q  <= mode;
        size_q  <= size;
        recip_q <= recip;
        ch_q    <= '0;
        elem_q  <= '0;
        out_ch  <= '0;
      end
      if (beat) begin
        if (last_ch) begin
          ch_q   <= '0;
          elem_q <= elem_q + 1'b1;
        end else begin
          ch_q <= ch_q + 1'b1;
        end
      end
      if (last_beat) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_ch    <= '0;
      end else if (out_hs) begin
        if (last_out) begin
          out_valid <= 1'b0;
        end else begin
          out_ch   <= out_ch + 1'b1;
          out_data <= result;
        end
      end
    end
  end

endmodule

// File: tb/tb_global_pool_mc.sv
// Purpose: directed self-checking bench for global_pool_mc with NCH=4.
// Latency: checks first-output timing and per-channel handshake order.
// Backpressure: exercises in_valid gaps and out_ready stalls.
module tb_global_pool_mc;
  import gpool_pkg::*;

  localparam int NCH = 4;
  localparam int CHW = 2;

  logic           clk = 1'b0;
  logic           rst, start, mode, in_valid, out_ready;
  logic [CW-1:0]  size;
  logic [DW-1:0]  recip, in_data, out_data;
  logic           in_ready, out_valid, busy, done;
  logic [CHW-1:0] out_ch;

  int n_chk  = 0;
  int n_pass = 0;
  int in_vec [64];
  int exp_vec [NCH];

  always #5 clk = ~clk;

  global_pool_mc #(.NCH(NCH)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .size(size), .recip(recip),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  // Element e of channel c sits at beat e*NCH + c.
  task automatic set_elem(input int c, input int e, input int v);
    in_vec[e*NCH + c] = v;
  endtask

  task automatic run_job(input string name, input bit m, input int sz, input int rc,
                         input bit rnd, input bit stall);
    int total, nout, sent, got, dones, cyc, stalls, last_in, prev_d, prev_c;
    bit prev_hold, rdy_checked, first_seen;
    total = sz * NCH;
    nout  = (sz == 0) ? 0 : NCH;
    sent = 0; got = 0; dones = 0; cyc = 0; stalls = 0; last_in = -10;
    prev_hold = 0; rdy_checked = 0; first_seen = 0; prev_d = 0; prev_c = 0;
    mode = m; size = CW'(sz); recip = DW'(rc); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while ((got < nout || dones == 0) && cyc < 3000) begin
      if (prev_hold) begin
        check({name, "_hold_data"}, sdata(), prev_d);
        check({name, "_hold_ch"}, int'(out_ch), prev_c);
      end
      if (done) begin
        dones++;
        check({name, "_done_after_outputs"}, got, nout);
      end
      if (sent < total) begin
        in_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
        in_data  = DW'(in_vec[sent]);
      end else begin
        in_valid = 1'b1;
        in_data  = DW'(12345);
        if (!rdy_checked) begin
          check({name, "_in_ready_low"}, int'(in_ready), 0);
          rdy_checked = 1;
        end
      end
      out_ready = 1'b1;
      if (stall && out_valid && out_ch == 2'd2 && stalls < 3) begin
        out_ready = 1'b0;
        stalls++;
      end
      if (in_valid && in_ready && sent < total) begin
        sent++;
        last_in = cyc;
      end
      if (out_valid && !first_seen) begin
        first_seen = 1;
        check({name, "_first_out_cycle"}, cyc, last_in + 1);
      end
      if (out_valid && out_ready) begin
        check({name, "_ch"}, int'(out_ch), got);
        if (got < NCH) check({name, "_data"}, sdata(), exp_vec[got]);
        got++;
      end
      prev_hold = out_valid && !out_ready;
      prev_d    = sdata();
      prev_c    = int'(out_ch);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check({name, "_no_timeout"}, int'(cyc < 3000), 1);
    check({name, "_out_count"}, got, nout);
    check({name, "_done_count"}, dones, 1);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_done_after"}, int'(done), 0);
    if (stall) check({name, "_stall_cycles"}, stalls, 3);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; size = '0; recip = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", sdata(), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    check("idle_in_ready", int'(in_ready), 0);
    in_valid = 1'b0;

    // Average of a constant per channel gives that constant back.
    for (int c = 0; c < NCH; c++) begin
      for (int e = 0; e < 4; e++) set_elem(c, e, (c + 1) * 65536);
      exp_vec[c] = (c + 1) * 65536;
    end
    run_job("avg4", 1'b0, 4, 1 << 18, 1'b0, 1'b0);

    // Same job with input gaps and a 3-cycle stall on channel 2.
    run_job("avg4_bp", 1'b0, 4, 1 << 18, 1'b1, 1'b1);

    // Max mode, including an all-negative channel.
    set_elem(0, 0, -3 * 65536); set_elem(0, 1, -65536);
    for (int c = 1; c < NCH; c++) begin
      set_elem(c, 0, 0); set_elem(c, 1, 5);
    end
    exp_vec[0] = -65536; exp_vec[1] = 5; exp_vec[2] = 5; exp_vec[3] = 5;
    run_job("max2", 1'b1, 2, 0, 1'b0, 1'b0);
    run_job("max2_bp", 1'b1, 2, 0, 1'b1, 1'b1);

    // Reciprocal slightly below 1.0: floor drops one LSB.
    for (int c = 0; c < NCH; c++) begin
      set_elem(c, 0, 7 * 65536);
      exp_vec[c] = 458751;
    end
    run_job("avg1_floor", 1'b0, 1, (1 << 20) - 1, 1'b0, 1'b0);

    // Full-scale values: exact average at the extremes, then true saturation.
    for (int e = 0; e < 2; e++) begin
      set_elem(0, e, 524287); set_elem(1, e, 524287);
      set_elem(2, e, -524288); set_elem(3, e, -524288);
    end
    exp_vec[0] = 524287; exp_vec[1] = 524287; exp_vec[2] = -524288; exp_vec[3] = -524288;
    run_job("avg2_full", 1'b0, 2, 1 << 19, 1'b0, 1'b0);
    run_job("avg2_sat", 1'b0, 2, (1 << 20) - 1, 1'b0, 1'b0);

    // Zero-size job: no beats taken, no outputs, one done.
    run_job("size0", 1'b0, 0, 0, 1'b0, 1'b0);

    // Abort an avg job mid-accumulation, then run a fresh one.
    mode = 1'b0; size = CW'(2); recip = DW'((1 << 20) - 1); start = 1'b1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = DW'(999);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_in_ready", int'(in_ready), 0);
    for (int c = 0; c < NCH; c++) begin
      set_elem(c, 0, 7 * 65536);
      exp_vec[c] = 458751;
    end
    run_job("after_abort", 1'b0, 1, (1 << 20) - 1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
